radix4_online_mult_sequencer: RTL and testbench

Controller that runs one radix-4 online (MSD-first) multiplication on the existing digit-serial multiplier. It accepts two parallel signed-digit operands through a start/ready handshake. It clears the multiplier, streams operand digits MSD-first, skips the online delay, and collects product digits into a parallel result. It sits between the parallel register interface and the multiplier's x/y/z/full_result_sel/extern_reset pins.

---
 rtl/radix4_online_mult_sequencer_pkg.sv | 19 +
 rtl/radix4_online_mult_sequencer_digit_shifter.sv | 27 ++
 rtl/radix4_online_mult_sequencer.sv | 149 ++++++++++++++
 tb/tb_radix4_online_mult_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/radix4_online_mult_sequencer_pkg.sv
// Shared state encoding, constants and sizing helper for the radix-4 online multiplier sequencer.
package radix4_online_mult_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    FEED,
    DONE
  } seq_state_t;

  localparam int CLEAR_CYCLES = 2;
  localparam logic [2:0] ZERO_DIGIT = 3'b000;

  // Counter must reach DELTA + 2*NO_OF_DIGITS - 1 in full-result mode.
  function automatic int cnt_width(input int no_of_digits, input int delta);
    return $clog2(2 * no_of_digits + delta + 1);
  endfunction

endpackage

// File: rtl/radix4_online_mult_sequencer_digit_shifter.sv
// MSD-first parallel-load / shift-left register of signed digits; new digits enter at the LSD slot.
module radix4_digit_shifter #(
  parameter int DIGITS     = 16,
  parameter int RADIX_BITS = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic [DIGITS*RADIX_BITS-1:0] load_value,
  input  logic                         shift,
  input  logic [RADIX_BITS-1:0]        shift_in,
  output logic [DIGITS*RADIX_BITS-1:0] data
);

  localparam int W = DIGITS * RADIX_BITS;

  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
    end else if (load) begin
      data <= load_value;
    end else if (shift) begin
      data <= {data[W-RADIX_BITS-1:0], shift_in};
    end
  end

endmodule

// File: rtl/radix4_online_mult_sequencer.sv
// Sequencer for one radix-4 online multiplication on the digit-serial multiplier.
// Optional macro RADIX4_SEQ_BUSY_ERR_EN adds a sticky busy_err output for starts issued while busy.
module radix4_online_mult_sequencer
  import radix4_online_mult_sequencer_pkg::*;
#(
  parameter int NO_OF_DIGITS = 16,
  parameter int RADIX_BITS   = 3,
  parameter int DELTA        = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 full_sel,
  input  logic [NO_OF_DIGITS*RADIX_BITS-1:0]   x_op,
  input  logic [NO_OF_DIGITS*RADIX_BITS-1:0]   y_op,
  output logic                                 ready,
  output logic [RADIX_BITS-1:0]                mul_x,
  output logic [RADIX_BITS-1:0]                mul_y,
  output logic                                 mul_full_result_sel,
  output logic                                 mul_extern_reset,
  input  logic [RADIX_BITS-1:0]                mul_z,
  output logic [2*NO_OF_DIGITS*RADIX_BITS-1:0] result,
  output logic                                 result_valid
`ifdef RADIX4_SEQ_BUSY_ERR_EN
  ,
  output logic                                 busy_err
`endif
);

  localparam int W     = NO_OF_DIGITS * RADIX_BITS;
  localparam int CNT_W = cnt_width(NO_OF_DIGITS, DELTA);

  seq_state_t state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next, last_cnt;
  logic full_sel_q;
  logic accept, feed_shift, capture, feeding_operands;
  logic [W-1:0] x_sh, y_sh;
  logic [2*W-1:0] res_sh;
  logic unused_sh_bits;

  assign last_cnt = full_sel_q ? CNT_W'(DELTA + 2 * NO_OF_DIGITS - 1)
                               : CNT_W'(DELTA + NO_OF_DIGITS - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      full_sel_q <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        full_sel_q <= full_sel;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    feed_shift = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        if (cnt == CNT_W'(CLEAR_CYCLES - 1)) begin
          state_next = FEED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      FEED: begin
        feed_shift = 1'b1;
        // The first DELTA product digits are the multiplier's online delay and carry no value.
        capture    = (cnt >= CNT_W'(DELTA));
        if (cnt == last_cnt) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  radix4_digit_shifter #(.DIGITS(NO_OF_DIGITS), .RADIX_BITS(RADIX_BITS)) u_x_sh (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .load_value (x_op),
    .shift      (feed_shift),
    .shift_in   (RADIX_BITS'(ZERO_DIGIT)),
    .data       (x_sh)
  );

  radix4_digit_shifter #(.DIGITS(NO_OF_DIGITS), .RADIX_BITS(RADIX_BITS)) u_y_sh (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .load_value (y_op),
    .shift      (feed_shift),
    .shift_in   (RADIX_BITS'(ZERO_DIGIT)),
    .data       (y_sh)
  );

  radix4_digit_shifter #(.DIGITS(2 * NO_OF_DIGITS), .RADIX_BITS(RADIX_BITS)) u_res_sh (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .load_value ('0),
    .shift      (capture),
    .shift_in   (mul_z),
    .data       (res_sh)
  );

  assign unused_sh_bits = ^{x_sh[W-RADIX_BITS-1:0], y_sh[W-RADIX_BITS-1:0]};

  assign feeding_operands    = (state == FEED) && (cnt < CNT_W'(NO_OF_DIGITS));
  assign mul_x               = feeding_operands ? x_sh[W-1 -: RADIX_BITS] : RADIX_BITS'(ZERO_DIGIT);
  assign mul_y               = feeding_operands ? y_sh[W-1 -: RADIX_BITS] : RADIX_BITS'(ZERO_DIGIT);
  assign mul_extern_reset    = reset || (state == CLEAR);
  assign mul_full_result_sel = full_sel_q;
  assign ready               = (state == IDLE) || (state == DONE);
  assign result_valid        = (state == DONE);

  // Truncated products occupy only the low half of the shift register; move them to the MSD half.
  assign result = full_sel_q ? res_sh : {res_sh[W-1:0], {W{1'b0}}};

`ifdef RADIX4_SEQ_BUSY_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_err <= 1'b0;
    end else if (accept) begin
      busy_err <= 1'b0;
    end else if (start && !ready) begin
      busy_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_radix4_online_mult_sequencer.sv
// Self-checking bench: plays the multiplier's role and checks digit sequencing, latency and results.
module tb_radix4_online_mult_sequencer;

  localparam int N      = 16;
  localparam int RB     = 3;
  localparam int DELTA  = 2;
  localparam int W      = N * RB;
  localparam int NCLEAR = 2;

  logic clk = 1'b0;
  logic reset, start, full_sel;
  logic [W-1:0] x_op, y_op;
  logic ready, mul_full_result_sel, mul_extern_reset, result_valid;
  logic [RB-1:0] mul_x, mul_y, mul_z;
  logic [2*W-1:0] result;
`ifdef RADIX4_SEQ_BUSY_ERR_EN
  logic busy_err;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  radix4_online_mult_sequencer #(.NO_OF_DIGITS(N), .RADIX_BITS(RB), .DELTA(DELTA)) dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .full_sel            (full_sel),
    .x_op                (x_op),
    .y_op                (y_op),
    .ready               (ready),
    .mul_x               (mul_x),
    .mul_y               (mul_y),
    .mul_full_result_sel (mul_full_result_sel),
    .mul_extern_reset    (mul_extern_reset),
    .mul_z               (mul_z),
    .result              (result),
    .result_valid        (result_valid)
`ifdef RADIX4_SEQ_BUSY_ERR_EN
    ,
    .busy_err            (busy_err)
`endif
  );

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] randOperand();
    logic [W-1:0] v;
    for (int i = 0; i < N; i++) v[i*RB +: RB] = RB'($urandom_range(0, 7));
    return v;
  endfunction

  function automatic logic [2*W-1:0] randStream();
    logic [2*W-1:0] v;
    for (int i = 0; i < 2*N; i++) v[i*RB +: RB] = RB'($urandom_range(0, 7));
    return v;
  endfunction

  // Value of the MSD-first signed-digit string, scaled by 4^ndig.
  function automatic logic signed [79:0] decodeDigits(input logic [2*W-1:0] r, input int ndig);
    logic signed [79:0] acc;
    logic [RB-1:0] d;
    acc = '0;
    for (int i = 0; i < ndig; i++) begin
      d = r[2*W-1-i*RB -: RB];
      acc = acc * 4 + {{(80-RB){d[RB-1]}}, d};
    end
    return acc;
  endfunction

  // One complete operation. zs is the product digit stream the mock multiplier emits, MSD first,
  // starting DELTA cycles into the feed. Start is launched just after edge E and sampled at E+1,
  // so result_valid must first appear after edge E+3+DELTA+L.
  task automatic applyStimulus(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic fs,
                               input logic [2*W-1:0] zs, input bit poke);
    int L;
    logic [2*W-1:0] exp_res;
    logic [RB-1:0] exp_x, exp_y;
    L = fs ? 2*N : N;
    exp_res = zs;
    if (!fs) exp_res[W-1:0] = '0;

    @(posedge clk); #1;
    start = 1'b1; full_sel = fs; x_op = xv; y_op = yv;
    @(posedge clk); #1;
    start = 1'b0; full_sel = ~fs; x_op = randOperand(); y_op = randOperand();
    checkOutput("accept_ready", ready, 1'b0);
`ifdef RADIX4_SEQ_BUSY_ERR_EN
    checkOutput("accept_busy_err", busy_err, 1'b0);
`endif

    for (int c = 0; c < NCLEAR; c++) begin
      mul_z = RB'($urandom_range(0, 7));
      checkOutput($sformatf("clear%0d_ext_reset", c), mul_extern_reset, 1'b1);
      checkOutput($sformatf("clear%0d_mul_x", c), mul_x, '0);
      checkOutput($sformatf("clear%0d_mul_y", c), mul_y, '0);
      checkOutput($sformatf("clear%0d_valid", c), result_valid, 1'b0);
      @(posedge clk); #1;
    end

    for (int k = 0; k < DELTA + L; k++) begin
      mul_z = (k >= DELTA) ? zs[2*W-1-(k-DELTA)*RB -: RB] : RB'($urandom_range(0, 7));
      exp_x = (k < N) ? xv[W-1-k*RB -: RB] : '0;
      exp_y = (k < N) ? yv[W-1-k*RB -: RB] : '0;
      if (poke && k == 5) begin
        start = 1'b1; full_sel = ~fs; x_op = randOperand(); y_op = randOperand();
      end
      checkOutput($sformatf("feed%0d_mul_x", k), mul_x, exp_x);
      checkOutput($sformatf("feed%0d_mul_y", k), mul_y, exp_y);
      checkOutput($sformatf("feed%0d_ext_reset", k), mul_extern_reset, 1'b0);
      checkOutput($sformatf("feed%0d_full_sel", k), mul_full_result_sel, fs);
      checkOutput($sformatf("feed%0d_valid", k), {ready, result_valid}, 2'b00);
      @(posedge clk); #1;
      start = 1'b0;
    end

    mul_z = RB'($urandom_range(0, 7));
    checkOutput("done_valid", {ready, result_valid}, 2'b11);
    checkOutput("done_result", result, exp_res);
    checkOutput("done_full_sel", mul_full_result_sel, fs);
`ifdef RADIX4_SEQ_BUSY_ERR_EN
    checkOutput("done_busy_err", busy_err, poke);
`endif
    @(posedge clk); #1;
    mul_z = RB'($urandom_range(0, 7));
    checkOutput("done_hold_result", result, exp_res);
    checkOutput("done_hold_valid", result_valid, 1'b1);
  endtask

  // Starts a full-length run and applies reset during the FEED cycle with cnt = 5.
  task automatic abortRun();
    @(posedge clk); #1;
    start = 1'b1; full_sel = 1'b1; x_op = randOperand(); y_op = randOperand();
    @(posedge clk); #1;
    start = 1'b0;
    mul_z = 3'b011;
    repeat (NCLEAR + 5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_ready", ready, 1'b1);
    checkOutput("abort_valid", result_valid, 1'b0);
    checkOutput("abort_result", result, '0);
    checkOutput("abort_ext_reset", mul_extern_reset, 1'b1);
    checkOutput("abort_mul_x", mul_x, '0);
    reset = 1'b0;
    #1;
    checkOutput("abort_release_ext_reset", mul_extern_reset, 1'b0);
  endtask

  initial begin
    logic [63:0] prod;
    logic [2*W-1:0] gold;
    logic [W-1:0] one_msd;

    reset = 1'b1; start = 1'b0; full_sel = 1'b0; x_op = '0; y_op = '0; mul_z = '0;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("reset_ready", ready, 1'b1);
      checkOutput("reset_valid", result_valid, 1'b0);
      checkOutput("reset_result", result, '0);
      checkOutput("reset_ext_reset", mul_extern_reset, 1'b1);
      checkOutput("reset_mul_xy", {mul_x, mul_y}, '0);
      checkOutput("reset_full_sel", mul_full_result_sel, 1'b0);
`ifdef RADIX4_SEQ_BUSY_ERR_EN
      checkOutput("reset_busy_err", busy_err, 1'b0);
`endif
    end
    reset = 1'b0;
    #1;
    checkOutput("release_ext_reset", mul_extern_reset, 1'b0);

    // Golden pair: 0.1 (radix 4) squared is 0.01, i.e. 4^30 when scaled by 4^32.
    one_msd = '0;
    one_msd[W-1 -: RB] = 3'b001;
    prod = (64'(1) << 30) * (64'(1) << 30);
    for (int i = 0; i < 2*N; i++) gold[2*W-1-i*RB -: RB] = {1'b0, prod[63-2*i -: 2]};

    applyStimulus(one_msd, one_msd, 1'b0, gold, 1'b0);
    checkOutput("golden_trunc_value", decodeDigits(result, N), 80'(prod >> 32));
    checkOutput("golden_trunc_low_zero", result[W-1:0], '0);
    applyStimulus(one_msd, one_msd, 1'b1, gold, 1'b0);
    checkOutput("golden_full_value", decodeDigits(result, 2*N), 80'(prod));

    for (int t = 0; t < 6; t++) begin
      applyStimulus(randOperand(), randOperand(), 1'($urandom_range(0, 1)), randStream(), t == 2);
    end

    abortRun();
    applyStimulus(randOperand(), randOperand(), 1'b0, randStream(), 1'b0);
    applyStimulus(randOperand(), randOperand(), 1'b1, randStream(), 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
